// File: rtl/logic_reduce_acc_pkg.sv
// Shared types for the packet bitwise-reduction accumulator.
package logic_reduce_acc_pkg;

    typedef enum logic [1:0] {
        OP_AND = 2'b00,
        OP_OR  = 2'b01,
        OP_XOR = 2'b10,
        OP_NOR = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_ACC  = 2'b01,
        S_DONE = 2'b10
    } state_e;

endpackage

// File: rtl/logic_reduce_acc_if.sv
// Word-stream input and result output of the reduction accumulator.
interface logic_reduce_acc_if #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 8
);
    logic [1:0]       op;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [CNT_W-1:0] out_count;

    modport master (
        output op, in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_count
    );

    modport slave (
        input  op, in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_count
    );
endinterface

// File: rtl/logic_word_op.sv
// Combinational WIDTH-wide two-operand AND/OR/XOR word gate.
module logic_word_op
    import logic_reduce_acc_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  op_e              op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);

    // NOR folds as OR here; the caller applies the final inversion.
    always_comb begin
        y = a | b;
        case (op)
            OP_AND:  y = a & b;
            OP_XOR:  y = a ^ b;
            default: y = a | b;
        endcase
    end

endmodule

// File: rtl/logic_reduce_acc.sv
// Packet bitwise reducer: folds a valid/ready word stream with AND/OR/XOR/NOR
// and presents one result word plus a saturating beat count.
module logic_reduce_acc
    import logic_reduce_acc_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CNT_W = 8
) (
    input logic               clk,
    input logic               rst_n,
    logic_reduce_acc_if.slave bus
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] op_res;
    logic [CNT_W-1:0] cnt_q;
    op_e              op_q;
    logic             beat;
    logic             xfer;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + CNT_W'(1);
    endfunction

    assign beat = bus.in_valid && bus.in_ready;
    assign xfer = bus.out_valid && bus.out_ready;

    logic_word_op #(.WIDTH(WIDTH)) u_word_op (
        .op (op_q),
        .a  (acc_q),
        .b  (bus.in_data),
        .y  (op_res)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (beat) state_d = bus.in_last ? S_DONE : S_ACC;
            S_ACC:   if (beat && bus.in_last) state_d = S_DONE;
            S_DONE:  if (xfer) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Handshake flags depend on registered state only.
    always_comb begin
        bus.in_ready  = (state_q != S_DONE);
        bus.out_valid = (state_q == S_DONE);
    end

    // The first beat loads the accumulator and latches op; later beats fold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            cnt_q <= '0;
            op_q  <= OP_AND;
        end else if (beat) begin
            if (state_q == S_IDLE) begin
                acc_q <= bus.in_data;
                op_q  <= op_e'(bus.op);
                cnt_q <= CNT_W'(1);
            end else begin
                acc_q <= op_res;
                cnt_q <= sat_inc(cnt_q);
            end
        end
    end

    assign bus.out_data  = (op_q == OP_NOR) ? ~acc_q : acc_q;
    assign bus.out_count = cnt_q;

endmodule

// File: tb/tb_logic_reduce_acc.sv
// Directed bench for logic_reduce_acc: default build plus a CNT_W=2 build.
module tb_logic_reduce_acc;
    import logic_reduce_acc_pkg::*;

    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;

    logic_reduce_acc_if #(.WIDTH(16), .CNT_W(8)) a_if ();
    logic_reduce_acc_if #(.WIDTH(16), .CNT_W(2)) b_if ();

    logic_reduce_acc #(.WIDTH(16), .CNT_W(8)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (a_if)
    );

    logic_reduce_acc #(.WIDTH(16), .CNT_W(2)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic beat(input bit sel_b, input logic [15:0] d, input logic last, input op_e o);
        if (sel_b) begin
            b_if.in_valid = 1'b1; b_if.in_data = d; b_if.in_last = last; b_if.op = o;
        end else begin
            a_if.in_valid = 1'b1; a_if.in_data = d; a_if.in_last = last; a_if.op = o;
        end
        @(posedge clk); #1;
        a_if.in_valid = 1'b0; a_if.in_last = 1'b0;
        b_if.in_valid = 1'b0; b_if.in_last = 1'b0;
    endtask

    task automatic take(input bit sel_b);
        if (sel_b) b_if.out_ready = 1'b1;
        else       a_if.out_ready = 1'b1;
        @(posedge clk); #1;
        a_if.out_ready = 1'b0;
        b_if.out_ready = 1'b0;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n = 1'b0;
        a_if.op = OP_AND; a_if.in_valid = 1'b0; a_if.in_data = '0; a_if.in_last = 1'b0; a_if.out_ready = 1'b0;
        b_if.op = OP_AND; b_if.in_valid = 1'b0; b_if.in_data = '0; b_if.in_last = 1'b0; b_if.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(a_if.in_ready), 32'd1);
        check("rst_out_valid", 32'(a_if.out_valid), 32'd0);
        check("rst_out_data", 32'(a_if.out_data), 32'h0);
        check("rst_out_count", 32'(a_if.out_count), 32'd0);
        check("rst_b_out_valid", 32'(b_if.out_valid), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // OR packet of three beats, with latency check
        beat(0, 16'h0001, 1'b0, OP_OR);
        check("or_no_valid_mid", 32'(a_if.out_valid), 32'd0);
        beat(0, 16'h0100, 1'b0, OP_AND);
        beat(0, 16'h8000, 1'b1, OP_AND);
        check("or_valid_latency", 32'(a_if.out_valid), 32'd1);
        check("or_in_ready_done", 32'(a_if.in_ready), 32'd0);
        check("or_data", 32'(a_if.out_data), 32'h8101);
        check("or_count", 32'(a_if.out_count), 32'd3);
        take(0);
        check("or_valid_cleared", 32'(a_if.out_valid), 32'd0);
        check("or_ready_back", 32'(a_if.in_ready), 32'd1);

        // AND single beat
        beat(0, 16'hF0F0, 1'b1, OP_AND);
        check("and1_data", 32'(a_if.out_data), 32'hF0F0);
        check("and1_count", 32'(a_if.out_count), 32'd1);
        take(0);

        // XOR two beats
        beat(0, 16'hFFFF, 1'b0, OP_XOR);
        beat(0, 16'h00FF, 1'b1, OP_XOR);
        check("xor_data", 32'(a_if.out_data), 32'hFF00);
        check("xor_count", 32'(a_if.out_count), 32'd2);
        take(0);

        // NOR two beats, then hold under backpressure
        beat(0, 16'h0000, 1'b0, OP_NOR);
        beat(0, 16'h0001, 1'b1, OP_NOR);
        for (int i = 0; i < 5; i++) begin
            check("bp_data", 32'(a_if.out_data), 32'hFFFE);
            check("bp_count", 32'(a_if.out_count), 32'd2);
            check("bp_in_ready", 32'(a_if.in_ready), 32'd0);
            check("bp_out_valid", 32'(a_if.out_valid), 32'd1);
            @(posedge clk); #1;
        end
        take(0);
        check("bp_release_ready", 32'(a_if.in_ready), 32'd1);
        check("bp_release_valid", 32'(a_if.out_valid), 32'd0);

        // op changes mid-packet must be ignored
        beat(0, 16'h0000, 1'b0, OP_OR);
        beat(0, 16'h000F, 1'b0, OP_AND);
        beat(0, 16'h00F0, 1'b1, OP_AND);
        check("optog_data", 32'(a_if.out_data), 32'h00FF);
        check("optog_count", 32'(a_if.out_count), 32'd3);
        take(0);

        // Saturating count on the CNT_W=2 build
        beat(1, 16'h0001, 1'b0, OP_XOR);
        beat(1, 16'h0002, 1'b0, OP_XOR);
        beat(1, 16'h0004, 1'b0, OP_XOR);
        beat(1, 16'h0008, 1'b0, OP_XOR);
        beat(1, 16'h0010, 1'b0, OP_XOR);
        beat(1, 16'h0020, 1'b1, OP_XOR);
        check("sat_valid", 32'(b_if.out_valid), 32'd1);
        check("sat_count", 32'(b_if.out_count), 32'd3);
        check("sat_data", 32'(b_if.out_data), 32'h003F);
        take(1);
        check("sat_cleared", 32'(b_if.out_valid), 32'd0);

        // Reset mid-packet discards the partial packet
        beat(0, 16'hFFFF, 1'b0, OP_OR);
        beat(0, 16'hFF00, 1'b0, OP_OR);
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 32'(a_if.out_valid), 32'd0);
        check("midrst_in_ready", 32'(a_if.in_ready), 32'd1);
        check("midrst_count", 32'(a_if.out_count), 32'd0);
        check("midrst_data", 32'(a_if.out_data), 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("postrst_no_valid", 32'(a_if.out_valid), 32'd0);
        beat(0, 16'h1234, 1'b1, OP_OR);
        check("postrst_valid", 32'(a_if.out_valid), 32'd1);
        check("postrst_data", 32'(a_if.out_data), 32'h1234);
        check("postrst_count", 32'(a_if.out_count), 32'd1);
        take(0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
